mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares one single-port unified 16-bit memory between three requesters: CPU instruction fetch (if), CPU data load/store (dm) and an external loader/debug port (ext). Fixed-priority arbitration ext > dm > if, with a starvation guard, a bus timeout and a stall output that freezes the CPU while its accesses are pending. Sits between CPU and memory, replacing the direct instruction and data memory hookups.

Parameters:
ADDR_W, 16, address width of all ports
DATA_W, 16, data width of all ports
STARVE_LIMIT, 4, consecutive lost arbitrations before dm/if is forced to win (1..15)
TIMEOUT, 255, cycles waiting for mem_ack before the access is aborted (1..255)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_ack  out  1  one-cycle completion pulse for data
ext_req / ext_we / ext_addr / ext_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as dm
ext_ack  out  1  one-cycle completion pulse for loader
rsp_data  out  DATA_W  read data, valid in the cycle any *_ack is high
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, latency >= 1 cycle after mem_req
cpu_stall  out  1  (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational
bus_err  out  1  sticky: set on any timeout, cleared only by reset

Behaviour:
- Reset (rst=0, async): state IDLE; all acks, mem_req, mem_we, bus_err = 0; mem_addr, mem_wdata, rsp_data = 0; starvation and timeout counters = 0. A transaction in flight is dropped; the memory must tolerate an abandoned mem_req.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: when any req is high, pick the winner; latch its id, addr, we and wdata into registers; go to ISSUE. If no req is high, stay in IDLE.
- Pick order:
  - if a starvation counter == STARVE_LIMIT, that requester wins (dm before if when both are saturated);
  - otherwise ext > dm > if.
- Starvation counters (dm, if only), updated on each IDLE arbitration:
  - +1 when req is high and the requester loses (saturate at STARVE_LIMIT);
  - clear on grant or when req is low.
- ISSUE: mem_req=1 with the latched addr, we and wdata, all stable. Timeout counter increments every cycle.
  - mem_ack=1: latch mem_rdata into rsp_data (0 for writes); go to RESP.
  - Counter reaches TIMEOUT before mem_ack: drop mem_req, set bus_err, rsp_data=0; go to RESP.
  - mem_ack arriving in the same cycle the counter reaches TIMEOUT counts as success.
- RESP: exactly one *_ack=1 for the granted id; mem_req=0; next state IDLE. Requests are ignored in RESP, so the old req still being high is not re-granted. A requester drops req, or presents a new request, in the cycle after its ack.
- Minimum transaction: grant edge → ISSUE (1) → mem_ack → RESP (1) → IDLE. Zero-wait memory gives 3 cycles req-to-ack; no back-to-back issue.
- Requests arriving while busy wait in their req line; no queuing beyond one outstanding transaction.
- Address and data changes on a held req are illegal (assertion), not tracked.

Decomposition:
- Package mem_arb_pkg: state enum {IDLE, ISSUE, RESP}; requester id enum {ID_NONE, ID_IF, ID_DM, ID_EXT}; default STARVE_LIMIT and TIMEOUT constants.
- One combinational sub-module, arb_starve_pick: takes the 3 reqs and 2 counters and returns the winner id plus next counter values. The FSM and memory-side registers stay in mem_arbiter.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0010; memory acks 1 cycle after mem_req with 0xABCD → mem_addr=0x0010, if_ack pulses 3 cycles after req, rsp_data=0xABCD, cpu_stall high until ack.
- Priority: if, dm (store 0x1234→0x0200) and ext (store 0x5555→0x0300) raised together → order ext, dm, if; each ack is 1 cycle wide and no request is granted twice.
- Starvation: ext_req held high continuously with if_req=1, STARVE_LIMIT=4 → if granted on its 5th arbitration, before the next ext grant.
- Timeout: TIMEOUT=8, memory never acks dm load → mem_req drops after 8 ISSUE cycles; dm_ack=1, rsp_data=0, bus_err=1 and stays 1; next ext access proceeds normally.
- Reset mid-ISSUE: rst driven low asynchronously while mem_req=1 → mem_req, acks and bus_err go to 0 immediately; after release, a new if_req completes normally.
- Wait states: memory acks 5 cycles after mem_req → mem_addr/mem_we/mem_wdata stable for all 5 cycles; ack arrives 7 cycles after req.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the three-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef enum logic [1:0] {ID_NONE, ID_IF, ID_DM, ID_EXT} req_id_t;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;

endpackage

// File: rtl/arb_starve_pick.sv
// Fixed-priority pick (ext > dm > if) with a starvation override for dm and if.
module arb_starve_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       ext_req,
  input  logic [3:0] if_cnt,
  input  logic [3:0] dm_cnt,
  output logic [1:0] winner,
  output logic [3:0] if_cnt_next,
  output logic [3:0] dm_cnt_next
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  req_id_t win;

  always_comb begin
    win = ID_NONE;
    // A saturated counter beats the fixed order; dm goes first if both are.
    if (dm_req && dm_cnt == LIMIT)      win = ID_DM;
    else if (if_req && if_cnt == LIMIT) win = ID_IF;
    else if (ext_req)                   win = ID_EXT;
    else if (dm_req)                    win = ID_DM;
    else if (if_req)                    win = ID_IF;
  end

  always_comb begin
    dm_cnt_next = '0;
    if_cnt_next = '0;
    if (dm_req && win != ID_DM)
      dm_cnt_next = (dm_cnt == LIMIT) ? LIMIT : dm_cnt + 4'd1;
    if (if_req && win != ID_IF)
      if_cnt_next = (if_cnt == LIMIT) ? LIMIT : if_cnt + 4'd1;
  end

  assign winner = win;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory shared by fetch, data and loader ports: one outstanding
// access at a time, with starvation guard, bus timeout and CPU stall.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              cpu_stall,
  output logic              bus_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_next;
  req_id_t           id_q, pick_id;
  logic [1:0]        pick_win;
  logic [3:0]        if_cnt, dm_cnt, if_cnt_next, dm_cnt_next;
  logic [7:0]        tcnt;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [DATA_W-1:0] wdata_q, sel_wdata, rsp_q;
  logic              we_q, sel_we, err_q;

  arb_starve_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .ext_req     (ext_req),
    .if_cnt      (if_cnt),
    .dm_cnt      (dm_cnt),
    .winner      (pick_win),
    .if_cnt_next (if_cnt_next),
    .dm_cnt_next (dm_cnt_next)
  );

  assign pick_id = req_id_t'(pick_win);

  always_comb begin
    sel_addr  = if_addr;
    sel_we    = 1'b0;
    sel_wdata = '0;
    case (pick_id)
      ID_DM: begin
        sel_addr  = dm_addr;
        sel_we    = dm_we;
        sel_wdata = dm_wdata;
      end
      ID_EXT: begin
        sel_addr  = ext_addr;
        sel_we    = ext_we;
        sel_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (if_req || dm_req || ext_req) state_next = ISSUE;
      // An ack in the final timeout cycle still wins over the abort.
      ISSUE:   if (mem_ack || tcnt == TO_LAST) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q    <= ID_NONE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
      tcnt    <= '0;
      if_cnt  <= '0;
      dm_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if_cnt <= if_cnt_next;
          dm_cnt <= dm_cnt_next;
          tcnt   <= '0;
          if (state_next == ISSUE) begin
            id_q    <= pick_id;
            addr_q  <= sel_addr;
            we_q    <= sel_we;
            wdata_q <= sel_wdata;
          end
        end
        ISSUE: begin
          tcnt <= tcnt + 8'd1;
          if (mem_ack) begin
            rsp_q <= we_q ? '0 : mem_rdata;
          end else if (tcnt == TO_LAST) begin
            rsp_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req   = (state == ISSUE);
    mem_we    = (state == ISSUE) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ack    = (state == RESP) && (id_q == ID_IF);
    dm_ack    = (state == RESP) && (id_q == ID_DM);
    ext_ack   = (state == RESP) && (id_q == ID_EXT);
    rsp_data  = rsp_q;
    bus_err   = err_q;
    cpu_stall = (if_req && !if_ack) || (dm_req && !dm_ack);
  end

  // Requesters must hold their access fields steady until acked.
  ap_if_hold: assert property (@(posedge clk) disable iff (!rst)
    (if_req && !if_ack) |=> $stable(if_addr));
  ap_dm_hold: assert property (@(posedge clk) disable iff (!rst)
    (dm_req && !dm_ack) |=> ($stable(dm_addr) && $stable(dm_we) && $stable(dm_wdata)));
  ap_ext_hold: assert property (@(posedge clk) disable iff (!rst)
    (ext_req && !ext_ack) |=> ($stable(ext_addr) && $stable(ext_we) && $stable(ext_wdata)));

endmodule
